// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//
// Detects the serial pattern 1,0,1,1 (first-received bit first) on i, using
// only the samples taken in cycles where en=1. Overlapping matches are
// allowed. Each completed pattern raises a one-cycle registered match pulse
// and bumps a saturating match counter. A sticky sat flag reports that the
// counter has reached its maximum.
//
// Ports
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   sample strobe; i is consumed only when en=1
//   i        in   serial data bit
//   clr      in   synchronous clear of count and sat (FSM unaffected)
//   match    out  one-cycle pulse after the edge that enters S1011
//   count    out  CNT_W-bit saturating match counter
//   sat      out  sticky flag, set when count reaches 2^CNT_W-1
//   state_o  out  registered FSM state, for debug
//
// Parameter CNT_W: counter width, legal range 2..16.
// Every output is taken directly from a flop.
// -----------------------------------------------------------------------------
module seq_detector #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             i,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S0    = 3'd0,  // nothing matched
    S1    = 3'd1,  // "1"
    S10   = 3'd2,  // "10"
    S101  = 3'd3,  // "101"
    S1011 = 3'd4   // pattern complete
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q,   sat_d;
  logic             enter_match;

  // Next-state logic. Unused encodings fall back to S0 even without en so a
  // corrupted state register recovers in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      if (en) state_d = i ? S1    : S0;
      S1:      if (en) state_d = i ? S1    : S10;
      S10:     if (en) state_d = i ? S101  : S0;
      S101:    if (en) state_d = i ? S1011 : S10;
      S1011:   if (en) state_d = i ? S1    : S10;
      default: state_d = S0;
    endcase
  end

  // S1011 is only entered from S101 on a qualified 1, and it has no
  // self-loop, so this fires exactly once per completed pattern even if
  // en stays low afterwards and the FSM sits in S1011.
  assign enter_match = en && (state_q == S101) && i;

  always_comb begin
    match_d = enter_match;
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      // clr wins over a coinciding match; the FSM and match are untouched.
      count_d = '0;
      sat_d   = 1'b0;
    end else if (enter_match) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end
      sat_d = sat_q | (count_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S0;
      match_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match   = match_q;
  assign count   = count_q;
  assign sat     = sat_q;
  assign state_o = state_q;

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter CNT_W, default 8: width of the match counter; the legal range is 2..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; the block has one clock and no other reset.
REQ-004 en  input  1  sample strobe; i is consumed only in cycles where en=1 (typically driven by the upstream mod-3 FSM q output).
REQ-005 i  input  1  serial data bit, sampled on the rising clk edge when en=1.
REQ-006 clr  input  1  synchronous clear of count and sat.
REQ-007 match  output  1  one-cycle pulse when the pattern 1011 completes.
REQ-008 count  output  CNT_W  number of matches since reset or clr, saturating.
REQ-009 sat  output  1  sticky flag; set when count reaches its maximum value.
REQ-010 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-011 The block shall detect the bit sequence 1,0,1,1 (first-received bit first) on i, counting only en-qualified samples, with overlapping matches allowed.
REQ-012 The FSM shall have five states with fixed encodings: S0=0 (nothing matched), S1=1 ("1"), S10=2 ("10"), S101=3 ("101"), S1011=4 (pattern complete).
REQ-013 On an en=1 edge the FSM shall take these transitions:
  - S0: 0 -> S0, 1 -> S1
  - S1: 0 -> S10, 1 -> S1
  - S10: 0 -> S0, 1 -> S101
  - S101: 0 -> S10, 1 -> S1011
  - S1011: 0 -> S10, 1 -> S1
REQ-014 When en=0, the FSM, count and sat shall hold, except for the effect of clr.
REQ-015 Encodings 5..7 shall transition to S0 on the next clk edge, regardless of en.
REQ-016 match shall be registered: high for exactly the one cycle after the edge that enters S1011, low otherwise, even if en stays low and the FSM remains in S1011.
REQ-017 On the edge that enters S1011, count shall increment by 1, so count and match update on the same edge (latency of 1 clk from the completing sample).
REQ-018 count shall saturate at 2^CNT_W-1 and never wrap; sat shall go high on the edge where count becomes 2^CNT_W-1.
REQ-019 Once set, sat shall stay high until clr or reset.
REQ-020 clr=1 shall set count=0 and sat=0 on the next edge and shall not affect the FSM state.
REQ-021 When clr=1 coincides with a completing sample, clr shall win (count=0, sat=0), while match still pulses and the FSM still enters S1011.
REQ-022 state_o shall equal the registered state.
REQ-023 The block shall contain no combinational path from any input to any output.

Reset
REQ-024 While reset_n=0, all outputs shall hold their reset values: state=S0, match=0, count=0, sat=0.
REQ-025 reset_n assertion shall take effect immediately without a clk edge, including mid-pattern (the partial match is discarded).
REQ-026 After reset_n deassertion, the first en sample shall be treated as the first bit of a new sequence.
REQ-027 clr and en shall have no effect while reset_n=0.

Verification
REQ-028 Reset, then en=1 every cycle with i=1,0,1,1 -> match=1 for one cycle after the 4th edge; count=1; state_o=4.
REQ-029 en=1 every cycle with i=1,0,1,1,0,1,1 -> two match pulses, 3 cycles apart; count=2 (overlap).
REQ-030 en pulsed every 3rd cycle (mod-3 FSM pattern), i=1,0,1,1 on the strobed cycles and junk on the others -> exactly one match; junk bits ignored.
REQ-031 CNT_W=2, 5 matches -> count sequence 1,2,3,3,3; sat=1 from the 3rd match onward; then clr -> count=0, sat=0.
REQ-032 Samples i=1,0,1, then reset_n pulsed low asynchronously between edges, then i=1 -> no match; state_o=1.
REQ-033 clr=1 on the completing edge with count=5 -> match=1, count=0.
